// File: rtl/store_buffer_if.sv
// Core-side handshake bundle of the store buffer: store push, load forwarding
// lookup, drain port to data memory and flush control.
interface store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [63:0]       st_data;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [63:0]       ld_fwd_data;
  logic              ld_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       write_data;
  logic              mem_write;
  logic              flush;
  logic              flush_done;
  logic [CNT_W-1:0]  count;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, flush,
    input  st_ready, ld_hit, ld_fwd_data, ld_stall, mem_addr, write_data,
           mem_write, flush_done, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, flush,
    output st_ready, ld_hit, ld_fwd_data, ld_stall, mem_addr, write_data,
           mem_write, flush_done, count
  );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer: drains one doubleword per cycle to memory, forwards
// exact-match loads from the youngest buffered store, stalls partial overlaps.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  sb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t            state_reg, state_next;
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [DEPTH-1:0]  valid_reg;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [63:0]       data_mem [DEPTH];

  logic st_ready_int;
  logic push, pop;

  assign st_ready_int = (count_reg < CNT_W'(DEPTH)) && (state_reg != FLUSH);
  assign push         = sb.st_valid && st_ready_int;
  assign pop          = (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CNT_W'(1);
    else if (!push && pop)
      count_next = count_reg - CNT_W'(1);
  end

  // Pointers, count and valid bits; entry payload below is deliberately unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (pop) begin
        head_reg            <= head_reg + PTR_W'(1);
        valid_reg[head_reg] <= 1'b0;
      end
      if (push) begin
        tail_reg            <= tail_reg + PTR_W'(1);
        valid_reg[tail_reg] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= sb.st_addr;
      data_mem[tail_reg] <= sb.st_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sb.flush) state_next = FLUSH;
               else if (push) state_next = ACTIVE;
      ACTIVE:  if (sb.flush) state_next = FLUSH;
               else if (count_next == '0) state_next = IDLE;
      FLUSH:   if (count_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-entry address comparison; distances taken both ways with wrap.
  logic [DEPTH-1:0] exact_vec, ovl_vec;
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      logic [ADDR_W-1:0] d_up, d_dn;
      assign d_up = addr_mem[gi] - sb.ld_addr;
      assign d_dn = sb.ld_addr - addr_mem[gi];
      assign exact_vec[gi] = valid_reg[gi] && (d_up == '0);
      assign ovl_vec[gi]   = valid_reg[gi] && (d_up != '0) &&
                             ((d_up < ADDR_W'(8)) || (d_dn < ADDR_W'(8)));
    end
  endgenerate

  // Walk oldest to youngest so the last exact match seen wins.
  logic [63:0] youngest_data;
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx           = '0;
    youngest_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_reg + PTR_W'(i);
      if (exact_vec[idx])
        youngest_data = data_mem[idx];
    end
  end

  always_comb begin
    sb.st_ready    = !reset && st_ready_int;
    sb.mem_write   = pop;
    sb.mem_addr    = pop ? addr_mem[head_reg] : '0;
    sb.write_data  = pop ? data_mem[head_reg] : '0;
    sb.flush_done  = (state_reg == FLUSH) && (count_reg == '0);
    sb.count       = count_reg;
    sb.ld_stall    = sb.ld_valid && (|ovl_vec);
    sb.ld_hit      = sb.ld_valid && (|exact_vec) && !(|ovl_vec);
    sb.ld_fwd_data = sb.ld_hit ? youngest_data : '0;
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized checks of store_buffer against a queue-based model
// of the buffer's architectural behaviour.
module tb_store_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) sb ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb.slave)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } ent_t;

  ent_t q[$];
  bit   fmode;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] e_ma, e_wd, e_fwd, diff;
    bit e_hit, e_stall;
    int n;
    n = q.size();
    e_ma = (n > 0) ? q[0].a : 64'h0;
    e_wd = (n > 0) ? q[0].d : 64'h0;
    e_hit = 0; e_stall = 0; e_fwd = 0;
    for (int i = 0; i < n; i++) begin
      diff = q[i].a - sb.ld_addr;
      if (diff == 0) begin
        e_hit = 1;
        e_fwd = q[i].d;
      end else if (diff < 8 || (64'h0 - diff) < 8) begin
        e_stall = 1;
      end
    end
    if (e_stall) begin e_hit = 0; e_fwd = 0; end
    if (!sb.ld_valid) begin e_hit = 0; e_stall = 0; e_fwd = 0; end
    chk({tag, ".st_ready"},   64'(sb.st_ready),   64'((n < DEPTH) && !fmode));
    chk({tag, ".mem_write"},  64'(sb.mem_write),  64'(n > 0));
    chk({tag, ".mem_addr"},   sb.mem_addr,        e_ma);
    chk({tag, ".write_data"}, sb.write_data,      e_wd);
    chk({tag, ".count"},      64'(sb.count),      64'(n));
    chk({tag, ".flush_done"}, 64'(sb.flush_done), 64'(fmode && n == 0));
    chk({tag, ".ld_hit"},     64'(sb.ld_hit),     64'(e_hit));
    chk({tag, ".ld_stall"},   64'(sb.ld_stall),   64'(e_stall));
    chk({tag, ".ld_fwd"},     sb.ld_fwd_data,     e_fwd);
  endtask

  task automatic model_update();
    bit accept, done;
    ent_t e;
    accept = sb.st_valid && (q.size() < DEPTH) && !fmode;
    done   = fmode && (q.size() == 0);
    if (q.size() > 0) void'(q.pop_front());
    if (accept) begin
      e.a = sb.st_addr;
      e.d = sb.st_data;
      q.push_back(e);
    end
    fmode = done ? 1'b0 : (fmode || sb.flush);
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    model_update();
    #1;
    $display("[TB] %s: st_valid=%0b st_addr=%h ld_addr=%h flush=%0b -> model count=%0d",
             tag, sb.st_valid, sb.st_addr, sb.ld_addr, sb.flush, q.size());
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, ".rst_mem_write"}, 64'(sb.mem_write),  64'h0);
    chk({tag, ".rst_count"},     64'(sb.count),      64'h0);
    chk({tag, ".rst_st_ready"},  64'(sb.st_ready),   64'h0);
    chk({tag, ".rst_ld_hit"},    64'(sb.ld_hit),     64'h0);
    chk({tag, ".rst_ld_stall"},  64'(sb.ld_stall),   64'h0);
    chk({tag, ".rst_flush_dn"},  64'(sb.flush_done), 64'h0);
    chk({tag, ".rst_mem_addr"},  sb.mem_addr,        64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    fmode = 0;
  endtask

  task automatic drive(input bit sv, input logic [63:0] sa, input logic [63:0] sd,
                       input bit lv, input logic [63:0] la, input bit fl);
    sb.st_valid = sv; sb.st_addr = sa; sb.st_data = sd;
    sb.ld_valid = lv; sb.ld_addr = la; sb.flush = fl;
  endtask

  function automatic logic [63:0] pick_addr();
    logic [63:0] base;
    case ($urandom_range(0, 9))
      0:       base = 64'hFFFF_FFFF_FFFF_FFFC;
      1:       base = 64'h0;
      default: base = 64'h40 + 64'(4 * $urandom_range(0, 5));
    endcase
    return base;
  endfunction

  initial begin
    fmode = 0;
    drive(0, 0, 0, 1, 64'h40, 0);
    do_reset("por");

    // Single push from idle drains next cycle, then buffer empties
    drive(1, 64'h28, 64'h8, 0, 0, 0);  cycle("push28");
    drive(0, 0, 0, 0, 0, 0);           cycle("drain28");
    cycle("empty28");

    // Back-to-back stream: st_ready held, count never above one
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'(8 * i), 64'(100 + i), 0, 0, 0);
      cycle($sformatf("stream%0d", i));
    end
    drive(0, 0, 0, 0, 0, 0); cycle("stream_tail");
    cycle("stream_idle");

    // Forwarding: older entry hits while a same-address push is excluded
    drive(1, 64'h40, 64'hAA, 1, 64'h40, 0); cycle("fwd_aa_push");
    drive(1, 64'h40, 64'hBB, 1, 64'h40, 0); cycle("fwd_aa_hit");
    drive(0, 0, 0, 1, 64'h40, 0);           cycle("fwd_bb_hit");
    cycle("fwd_empty");

    // Partial overlap stalls, disjoint doubleword does not
    drive(1, 64'h40, 64'h11, 1, 64'h44, 0); cycle("ovl_push");
    drive(1, 64'h40, 64'h22, 1, 64'h44, 0); cycle("ovl_44");
    drive(0, 0, 0, 1, 64'h48, 0);           cycle("ovl_48");
    drive(1, 64'h0, 64'h33, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0); cycle("wrap_push");
    drive(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);          cycle("wrap_stall");
    drive(0, 0, 0, 0, 64'h0, 0);                            cycle("ld_off");

    // Flush from idle pulses flush_done the next cycle
    drive(0, 0, 0, 0, 0, 1); cycle("fl_idle_req");
    drive(0, 0, 0, 0, 0, 0); cycle("fl_idle_done");
    cycle("fl_idle_after");

    // Flush with an entry buffered and stores still offered
    drive(1, 64'h80, 64'h55, 0, 0, 0); cycle("fl_act_push");
    drive(1, 64'h88, 64'h66, 0, 0, 1); cycle("fl_act_req");
    drive(1, 64'h90, 64'h77, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle($sformatf("fl_act_%0d", i));

    // Flush held high gives repeated pulses
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle($sformatf("fl_hold_%0d", i));
    drive(0, 0, 0, 0, 0, 0); cycle("fl_hold_rel");
    cycle("fl_hold_idle");

    // Reset with a buffered store discards it without writing memory
    drive(1, 64'hC0, 64'h99, 0, 0, 0); cycle("rst_mid_push");
    drive(0, 0, 0, 0, 0, 0);
    do_reset("rst_mid");
    for (int i = 0; i < 3; i++) cycle($sformatf("rst_after_%0d", i));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, pick_addr(), {$urandom, $urandom},
            $urandom_range(0, 1) == 1, pick_addr(), $urandom_range(0, 15) == 0);
      cycle($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
